// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   ID-stage hazard unit for the RV32IM pipeline. It resolves operand
//   forwarding from the downstream stages, detects load-use hazards, and
//   tracks a single outstanding multi-cycle MUL/DIV operation. That tracking
//   drives the RAW, WAW and structural stalls. It also reports the stall
//   cause and keeps a saturating count of stalled cycles.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   rs1_id, rs2_id            ID source registers
//   rs1_used_id, rs2_used_id  ID instruction actually reads rs1 / rs2
//   rd_id, we_id              ID destination register and write enable
//   is_mdu_id                 ID instruction is a multi-cycle MUL/DIV
//   rd_stage, we_stage        per-stage destination / write enable (0 = EX)
//   is_load_ex                EX instruction is a load
//   mdu_issue                 MDU op leaves ID this cycle (rd from rd_id)
//   flush                     pipeline flush, kills the outstanding MDU op
//   stall_pipeline            stall PC/IF/ID
//   stall_cause               00 none, 01 load-use, 10 MDU RAW/WAW, 11 MDU structural
//   forward_rs1, forward_rs2  0 = register file, i+1 = forward from stage i
//   mdu_busy, mdu_done        MDU op outstanding / result ready this cycle
//   stall_count               saturating count of stalled cycles
module hazard_scoreboard_unit #(
    parameter int NUM_FWD_STAGES = 3,
    parameter int MDU_LATENCY    = 34,
    parameter int CNT_W          = 32,
    parameter int SEL_W          = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [4:0]                    rs1_id,
    input  logic [4:0]                    rs2_id,
    input  logic                          rs1_used_id,
    input  logic                          rs2_used_id,
    input  logic [4:0]                    rd_id,
    input  logic                          we_id,
    input  logic                          is_mdu_id,
    input  logic [5*NUM_FWD_STAGES-1:0]   rd_stage,
    input  logic [NUM_FWD_STAGES-1:0]     we_stage,
    input  logic                          is_load_ex,
    input  logic                          mdu_issue,
    input  logic                          flush,
    output logic                          stall_pipeline,
    output logic [1:0]                    stall_cause,
    output logic [SEL_W-1:0]              forward_rs1,
    output logic [SEL_W-1:0]              forward_rs2,
    output logic                          mdu_busy,
    output logic                          mdu_done,
    output logic [CNT_W-1:0]              stall_count
);

    localparam logic [7:0] LAT_M1 = 8'(MDU_LATENCY - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic       busy;
    logic [4:0] mdu_rd;
    logic [7:0] cnt;
    logic       issue_ok;
    logic       lu_hz;
    logic       mr_hz;
    logic       ms_hz;
    logic       cnt_zero;

    // Forwarding: scan from the oldest stage down so the youngest match wins.
    always_comb begin
        forward_rs1 = '0;
        forward_rs2 = '0;
        for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
            if (we_stage[i] && rd_stage[5*i +: 5] == rs1_id && rs1_id != 5'd0)
                forward_rs1 = SEL_W'(i + 1);
            if (we_stage[i] && rd_stage[5*i +: 5] == rs2_id && rs2_id != 5'd0)
                forward_rs2 = SEL_W'(i + 1);
        end
    end

    assign cnt_zero = (cnt == 8'd0);

    assign lu_hz = is_load_ex && we_stage[0] && rd_stage[4:0] != 5'd0 &&
                   ((rs1_used_id && rs1_id == rd_stage[4:0]) ||
                    (rs2_used_id && rs2_id == rd_stage[4:0]));

    // MR stays up through the done cycle; the result is only forwardable
    // from EX on the following cycle.
    assign mr_hz = busy && mdu_rd != 5'd0 &&
                   ((rs1_used_id && rs1_id == mdu_rd) ||
                    (rs2_used_id && rs2_id == mdu_rd) ||
                    (we_id && rd_id == mdu_rd));

    // Released in the done cycle so a second MDU op can issue back-to-back.
    assign ms_hz = busy && !cnt_zero && is_mdu_id;

    // An issue while busy with cnt!=0 is illegal and simply ignored.
    assign issue_ok = mdu_issue && !flush && (!busy || cnt_zero);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            mdu_rd <= 5'd0;
            cnt    <= 8'd0;
        end else if (flush) begin
            busy <= 1'b0;
            cnt  <= 8'd0;
        end else if (issue_ok) begin
            busy   <= 1'b1;
            mdu_rd <= rd_id;
            cnt    <= LAT_M1;
        end else if (busy && !cnt_zero) begin
            cnt <= cnt - 8'd1;
        end else if (busy) begin
            busy <= 1'b0;
        end
    end

    assign mdu_busy = busy;
    assign mdu_done = busy && cnt_zero;

    // Stall outputs are forced low while reset is held, even though LU is
    // derived purely from inputs.
    always_comb begin
        stall_pipeline = reset_n && (lu_hz || mr_hz || ms_hz);
        stall_cause    = 2'b00;
        if (reset_n) begin
            if (ms_hz)
                stall_cause = 2'b11;
            else if (mr_hz)
                stall_cause = 2'b10;
            else if (lu_hz)
                stall_cause = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_count <= '0;
        else if (stall_pipeline)
            stall_count <= sat_inc(stall_count);
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

    localparam int N   = 3;
    localparam int L   = 4;
    localparam int CW  = 4;
    localparam int SW  = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk;
    logic            reset_n;
    logic [4:0]      rs1_id, rs2_id, rd_id;
    logic            rs1_used_id, rs2_used_id, we_id, is_mdu_id;
    logic [5*N-1:0]  rd_stage;
    logic [N-1:0]    we_stage;
    logic            is_load_ex, mdu_issue, flush;
    logic            stall_pipeline;
    logic [1:0]      stall_cause;
    logic [SW-1:0]   forward_rs1, forward_rs2;
    logic            mdu_busy, mdu_done;
    logic [CW-1:0]   stall_count;

    hazard_scoreboard_unit #(
        .NUM_FWD_STAGES(N), .MDU_LATENCY(L), .CNT_W(CW), .SEL_W(SW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_id(rd_id), .we_id(we_id), .is_mdu_id(is_mdu_id),
        .rd_stage(rd_stage), .we_stage(we_stage),
        .is_load_ex(is_load_ex), .mdu_issue(mdu_issue), .flush(flush),
        .stall_pipeline(stall_pipeline), .stall_cause(stall_cause),
        .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the outstanding op is described by the cycle index
    // at which its result becomes ready.
    int         t = 0;
    bit         m_active = 0;
    int         m_done_t = 0;
    logic [4:0] m_rd = 5'd0;
    int         m_scnt = 0;

    bit         e_busy, e_done, e_stall;
    logic [1:0] e_cause;
    int         e_f1, e_f2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fwd_exp(input logic [4:0] rs);
        if (rs == 5'd0) return 0;
        for (int i = 0; i < N; i++)
            if (we_stage[i] && rd_stage[5*i +: 5] == rs) return i + 1;
        return 0;
    endfunction

    task automatic model_eval();
        bit ms, mr, lu;
        e_busy = reset_n && m_active && (t <= m_done_t);
        e_done = e_busy && (t == m_done_t);
        ms = e_busy && (t < m_done_t) && is_mdu_id;
        mr = e_busy && m_rd != 5'd0 &&
             ((rs1_used_id && rs1_id == m_rd) || (rs2_used_id && rs2_id == m_rd) ||
              (we_id && rd_id == m_rd));
        lu = is_load_ex && we_stage[0] && rd_stage[4:0] != 5'd0 &&
             ((rs1_used_id && rs1_id == rd_stage[4:0]) || (rs2_used_id && rs2_id == rd_stage[4:0]));
        e_stall = reset_n && (lu || mr || ms);
        e_cause = !e_stall ? 2'd0 : ms ? 2'd3 : mr ? 2'd2 : 2'd1;
        e_f1 = fwd_exp(rs1_id);
        e_f2 = fwd_exp(rs2_id);
    endtask

    task automatic check_model();
        model_eval();
        chk("m_fwd1",  32'(forward_rs1),    32'(e_f1));
        chk("m_fwd2",  32'(forward_rs2),    32'(e_f2));
        chk("m_stall", 32'(stall_pipeline), 32'(e_stall));
        chk("m_cause", 32'(stall_cause),    32'(e_cause));
        chk("m_busy",  32'(mdu_busy),       32'(e_busy));
        chk("m_done",  32'(mdu_done),       32'(e_done));
        chk("m_count", 32'(stall_count),    32'(m_scnt));
    endtask

    task automatic model_update();
        bit sb;
        model_eval();
        if (!reset_n) begin
            m_active = 0;
            m_scnt   = 0;
        end else begin
            if (e_stall && m_scnt < CMAX) m_scnt++;
            sb = m_active && (t < m_done_t);
            assert (!(mdu_issue && !flush && sb))
            else begin
                bad++;
                $error("FAIL protocol issue_while_busy observed=1 expected=0");
            end
            if (flush)
                m_active = 0;
            else if (mdu_issue && !sb) begin
                m_active = 1;
                m_done_t = t + L;
                m_rd     = rd_id;
            end
        end
        t++;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rs1_id = 0; rs2_id = 0; rd_id = 0;
        rs1_used_id = 0; rs2_used_id = 0; we_id = 0; is_mdu_id = 0;
        rd_stage = '0; we_stage = '0;
        is_load_ex = 0; mdu_issue = 0; flush = 0;
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_busy",  32'(mdu_busy),       32'd0);
        chk("rst_stall", 32'(stall_pipeline), 32'd0);
        chk("rst_count", 32'(stall_count),    32'd0);
        m_active = 0;
        m_scnt   = 0;
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #1;
        cycle();
        chk("rst_done", 32'(mdu_done), 32'd0);
        cycle();
        reset_n = 1'b1;

        // T1 forwarding priority
        rs1_id = 5; we_stage = 3'b111; rd_stage = {5'd5, 5'd5, 5'd5};
        #1; chk("t1_fwd_ex", 32'(forward_rs1), 32'd1); cycle();
        we_stage = 3'b110;
        #1; chk("t1_fwd_ma", 32'(forward_rs1), 32'd2); cycle();
        rs1_id = 0;
        #1; chk("t1_fwd_x0", 32'(forward_rs1), 32'd0); cycle();

        // T2 load-use
        idle();
        is_load_ex = 1; we_stage = 3'b001; rd_stage[4:0] = 7; rs2_id = 7; rs2_used_id = 1;
        #1; chk("t2_lu_stall", 32'(stall_pipeline), 32'd1);
        chk("t2_lu_cause", 32'(stall_cause), 32'd1); cycle();
        rs2_used_id = 0;
        #1; chk("t2_unused", 32'(stall_pipeline), 32'd0);
        chk("t2_fwd2", 32'(forward_rs2), 32'd1); cycle();

        // T3 MDU RAW
        idle();
        mdu_issue = 1; is_mdu_id = 1; rd_id = 9; we_id = 1;
        #1; cycle();
        idle(); rs1_id = 9; rs1_used_id = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_stall", 32'(stall_pipeline), 32'd1);
            chk("t3_cause", 32'(stall_cause), 32'd2);
            chk("t3_done", 32'(mdu_done), 32'(k == 3));
            cycle();
        end
        #1; chk("t3_release", 32'(stall_pipeline), 32'd0);
        chk("t3_idle", 32'(mdu_busy), 32'd0); cycle();

        // T4 back-to-back MDU ops
        idle();
        mdu_issue = 1; is_mdu_id = 1; rd_id = 3; we_id = 1;
        #1; cycle();
        for (int k = 0; k < 4; k++) begin
            idle(); is_mdu_id = 1; rd_id = 4; we_id = 1; mdu_issue = (k == 3);
            #1;
            if (k < 3) begin
                chk("t4_struct_cause", 32'(stall_cause), 32'd3);
                chk("t4_struct_stall", 32'(stall_pipeline), 32'd1);
            end else begin
                chk("t4_done_release", 32'(stall_pipeline), 32'd0);
                chk("t4_done", 32'(mdu_done), 32'd1);
            end
            chk("t4_busy", 32'(mdu_busy), 32'd1);
            cycle();
        end
        idle();
        #1; chk("t4_busy_cont", 32'(mdu_busy), 32'd1);
        chk("t4_not_done", 32'(mdu_done), 32'd0);
        for (int k = 0; k < 4; k++) cycle();
        #1; chk("t4_drained", 32'(mdu_busy), 32'd0);

        // T5 flush mid-op, then async reset mid-op
        idle(); mdu_issue = 1; is_mdu_id = 1; rd_id = 6; we_id = 1;
        #1; cycle();
        idle(); #1; cycle();
        flush = 1;
        #1; chk("t5_busy_pre", 32'(mdu_busy), 32'd1); cycle();
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_flushed_busy", 32'(mdu_busy), 32'd0);
            chk("t5_flushed_done", 32'(mdu_done), 32'd0);
            cycle();
        end
        mdu_issue = 1; is_mdu_id = 1; rd_id = 6; we_id = 1;
        #1; cycle();
        idle(); rs2_id = 6; rs2_used_id = 1;
        #1; chk("t5_busy_again", 32'(mdu_busy), 32'd1);
        async_reset();

        // T6 stall counter saturation
        idle();
        is_load_ex = 1; we_stage = 3'b001; rd_stage[4:0] = 7; rs1_id = 7; rs1_used_id = 1;
        for (int k = 0; k < 20; k++) begin
            #1; chk("t6_count", 32'(stall_count), 32'(k > CMAX ? CMAX : k));
            cycle();
        end
        #1; chk("t6_saturated", 32'(stall_count), 32'(CMAX));

        // Randomized phase against the reference model
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 50) async_reset();
            rs1_id = 5'($urandom_range(0, 7));
            rs2_id = 5'($urandom_range(0, 7));
            rd_id  = 5'($urandom_range(0, 7));
            rs1_used_id = 1'($urandom);
            rs2_used_id = 1'($urandom);
            we_id       = 1'($urandom);
            is_mdu_id   = 1'($urandom);
            we_stage    = 3'($urandom);
            for (int i = 0; i < N; i++) rd_stage[5*i +: 5] = 5'($urandom_range(0, 7));
            is_load_ex  = ($urandom_range(0, 2) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            mdu_issue   = ($urandom_range(0, 3) == 0) && !(m_active && t < m_done_t);
            #1;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
